swc_alloc_arbiter: RTL and testbench

Round-robin scheduler that shares one page-allocator port between g_num_ports requesters, e.g. input block, output queues and freeing logic. It sequences one ALLOC / FREE / FORCE_FREE / SET_USECOUNT operation at a time. Each operation follows the allocator's strobe-until-done handshake. The result is returned to the granted requester. It sits between the switch-core clients and the page allocator.

---
 rtl/swc_alloc_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_swc_alloc_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swc_alloc_arbiter.sv
// Round-robin arbiter sharing one page-allocator port among g_num_ports clients.
// Define SWC_ALLOC_ARB_STATS_EN to build the occupied_o / peak_o page counters.
module swc_alloc_arbiter #(
    parameter int g_num_ports       = 4,
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [g_num_ports-1:0]                     rq_req_i,
    input  logic [2*g_num_ports-1:0]                   rq_op_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   rq_pg_addr_i,
    input  logic [g_num_ports*g_usecnt_width-1:0]      rq_usecnt_i,
    output logic [g_num_ports-1:0]                     rq_done_o,
    output logic [g_page_addr_width-1:0]               rq_pg_addr_o,
    output logic                                       rq_last_o,
    output logic                                       mm_alloc_o,
    output logic                                       mm_free_o,
    output logic                                       mm_force_free_o,
    output logic                                       mm_set_usecnt_o,
    output logic [g_page_addr_width-1:0]               mm_pg_addr_o,
    output logic [g_usecnt_width-1:0]                  mm_usecnt_o,
    input  logic                                       mm_done_i,
    input  logic [g_page_addr_width-1:0]               mm_pg_addr_alloc_i,
    input  logic                                       mm_no_mem_i,
    input  logic                                       mm_free_last_usecnt_i,
    output logic [g_page_addr_width:0]                 occupied_o,
    output logic [g_page_addr_width:0]                 peak_o,
    output logic [1:0]                                 state_o
);
    // Handshake: the granted client holds rq_req_i until its one-cycle rq_done_o pulse;
    // towards the allocator one strobe is held with stable data until mm_done_i.
    localparam int PW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
    localparam int AW = g_page_addr_width;
    localparam int UW = g_usecnt_width;

    localparam logic [1:0] OP_ALLOC      = 2'b00;
    localparam logic [1:0] OP_FREE       = 2'b01;
    localparam logic [1:0] OP_FORCE_FREE = 2'b10;
    localparam logic [1:0] OP_SET_USECNT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     pick;
    logic              pick_valid;
    int                idx;
    logic [g_num_ports-1:0] eligible;
    logic [1:0]        op_q;
    logic [AW-1:0]     pg_addr_q;
    logic [UW-1:0]     usecnt_q;
    logic [AW-1:0]     alloc_pg_q;
    logic              last_q;

    // ALLOCs are held back while the allocator is out of pages; other ops still go.
    always_comb begin
        for (int i = 0; i < g_num_ports; i++) begin
            eligible[i] = rq_req_i[i] && !((rq_op_i[2*i +: 2] == OP_ALLOC) && mm_no_mem_i);
        end
    end

    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        idx        = 0;
        for (int j = 0; j < g_num_ports; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= g_num_ports) idx = idx - g_num_ports;
            if (!pick_valid && eligible[idx]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_valid) state_next = S_BUSY;
            S_BUSY:  if (mm_done_i)  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            grant      <= '0;
            op_q       <= '0;
            pg_addr_q  <= '0;
            usecnt_q   <= '0;
            alloc_pg_q <= '0;
            last_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && pick_valid) begin
                grant     <= pick;
                op_q      <= rq_op_i[2*int'(pick) +: 2];
                pg_addr_q <= rq_pg_addr_i[AW*int'(pick) +: AW];
                usecnt_q  <= rq_usecnt_i[UW*int'(pick) +: UW];
            end
            if (state == S_BUSY && mm_done_i) begin
                alloc_pg_q <= mm_pg_addr_alloc_i;
                last_q     <= mm_free_last_usecnt_i;
            end
            if (state == S_RESP) begin
                rr_ptr <= (grant == PW'(g_num_ports - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_comb begin
        mm_alloc_o      = 1'b0;
        mm_free_o       = 1'b0;
        mm_force_free_o = 1'b0;
        mm_set_usecnt_o = 1'b0;
        rq_done_o       = '0;
        rq_pg_addr_o    = '0;
        rq_last_o       = 1'b0;
        if (state == S_BUSY) begin
            case (op_q)
                OP_ALLOC:      mm_alloc_o      = 1'b1;
                OP_FREE:       mm_free_o       = 1'b1;
                OP_FORCE_FREE: mm_force_free_o = 1'b1;
                default:       mm_set_usecnt_o = 1'b1;
            endcase
        end
        if (state == S_RESP) begin
            rq_done_o[grant] = 1'b1;
            if (op_q == OP_ALLOC) rq_pg_addr_o = alloc_pg_q;
            if (op_q == OP_FREE)  rq_last_o    = last_q;
        end
    end

    assign mm_pg_addr_o = pg_addr_q;
    assign mm_usecnt_o  = usecnt_q;
    assign state_o      = state;

`ifdef SWC_ALLOC_ARB_STATS_EN
    localparam logic [AW:0] OCC_MAX = {1'b1, {AW{1'b0}}};
    logic [AW:0] occ_q;
    logic [AW:0] peak_q;
    logic [AW:0] occ_next;
    logic        occ_inc;
    logic        occ_dec;

    // Counts move only when an operation actually completes at the allocator.
    always_comb begin
        occ_inc  = 1'b0;
        occ_dec  = 1'b0;
        occ_next = occ_q;
        if (state == S_BUSY && mm_done_i) begin
            occ_inc = (op_q == OP_ALLOC);
            occ_dec = (op_q == OP_FORCE_FREE) || (op_q == OP_FREE && mm_free_last_usecnt_i);
        end
        if (occ_inc && occ_q != OCC_MAX)   occ_next = occ_q + 1'b1;
        else if (occ_dec && occ_q != '0)   occ_next = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q  <= '0;
            peak_q <= '0;
        end else begin
            occ_q <= occ_next;
            if (occ_next > peak_q) peak_q <= occ_next;
        end
    end

    assign occupied_o = occ_q;
    assign peak_o     = peak_q;
`else
    assign occupied_o = '0;
    assign peak_o     = '0;
`endif

endmodule

// File: tb/tb_swc_alloc_arbiter.sv
// Randomized bench for swc_alloc_arbiter: a request-level round-robin model predicts
// grants, a page-pool allocator model answers strobes, a monitor checks every response.
module tb_swc_alloc_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int UW = 4;
    localparam int OCC_MAX = 1 << AW;
    localparam logic [1:0] OP_ALLOC = 2'b00;
    localparam logic [1:0] OP_FREE  = 2'b01;
    localparam logic [1:0] OP_FORCE = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    rq_req_i;
    logic [2*N-1:0]  rq_op_i;
    logic [N*AW-1:0] rq_pg_addr_i;
    logic [N*UW-1:0] rq_usecnt_i;
    logic [N-1:0]    rq_done_o;
    logic [AW-1:0]   rq_pg_addr_o;
    logic            rq_last_o;
    logic            mm_alloc_o, mm_free_o, mm_force_free_o, mm_set_usecnt_o;
    logic [AW-1:0]   mm_pg_addr_o;
    logic [UW-1:0]   mm_usecnt_o;
    logic            mm_done_i;
    logic [AW-1:0]   mm_pg_addr_alloc_i;
    logic            mm_no_mem_i;
    logic            mm_free_last_usecnt_i;
    logic [AW:0]     occupied_o;
    logic [AW:0]     peak_o;
    logic [1:0]      dbg_state;

    swc_alloc_arbiter #(
        .g_num_ports(N), .g_page_addr_width(AW), .g_usecnt_width(UW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rq_req_i(rq_req_i), .rq_op_i(rq_op_i), .rq_pg_addr_i(rq_pg_addr_i),
        .rq_usecnt_i(rq_usecnt_i), .rq_done_o(rq_done_o), .rq_pg_addr_o(rq_pg_addr_o),
        .rq_last_o(rq_last_o), .mm_alloc_o(mm_alloc_o), .mm_free_o(mm_free_o),
        .mm_force_free_o(mm_force_free_o), .mm_set_usecnt_o(mm_set_usecnt_o),
        .mm_pg_addr_o(mm_pg_addr_o), .mm_usecnt_o(mm_usecnt_o), .mm_done_i(mm_done_i),
        .mm_pg_addr_alloc_i(mm_pg_addr_alloc_i), .mm_no_mem_i(mm_no_mem_i),
        .mm_free_last_usecnt_i(mm_free_last_usecnt_i), .occupied_o(occupied_o),
        .peak_o(peak_o), .state_o(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        int           port;
        logic [1:0]   op;
        logic [AW-1:0] page;
        logic [UW-1:0] usecnt;
        int           strobe_cyc;
    } exp_t;
    typedef struct packed {
        logic [AW-1:0] page;
        logic          last;
        int            done_cyc;
    } res_t;

    exp_t exp_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   done_seen [N];
    int   use_cnt [OCC_MAX];
    int   lat = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rq_done"},  32'(rq_done_o), 0);
        check({tag, "_rq_page"},  32'(rq_pg_addr_o), 0);
        check({tag, "_rq_last"},  32'(rq_last_o), 0);
        check({tag, "_strobes"},  32'({mm_set_usecnt_o, mm_force_free_o, mm_free_o, mm_alloc_o}), 0);
        check({tag, "_mm_page"},  32'(mm_pg_addr_o), 0);
        check({tag, "_mm_ucnt"},  32'(mm_usecnt_o), 0);
        check({tag, "_occupied"}, 32'(occupied_o), 0);
        check({tag, "_peak"},     32'(peak_o), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_requests(input bit allow_new);
        for (int i = 0; i < N; i++) begin
            if (done_seen[i]) begin
                done_seen[i] = 1'b0;
                rq_req_i[i]  = 1'b0;
            end
            if (!rq_req_i[i] && allow_new && $urandom_range(0, 3) == 0) begin
                rq_op_i[2*i +: 2]       = 2'($urandom_range(0, 3));
                rq_pg_addr_i[AW*i +: AW] = AW'($urandom_range(0, 15));
                rq_usecnt_i[UW*i +: UW]  = UW'($urandom_range(1, 3));
                rq_req_i[i]             = 1'b1;
            end
        end
        if (allow_new && $urandom_range(0, 9) == 0) mm_no_mem_i = ~mm_no_mem_i;
    endtask

    // Page-pool allocator model: answers each strobe after 0..4 extra cycles.
    task automatic respond();
        int   p;
        res_t r;
        if (mm_done_i) begin
            mm_done_i             = 1'b0;
            mm_free_last_usecnt_i = 1'b0;
        end else if (mm_alloc_o || mm_free_o || mm_force_free_o || mm_set_usecnt_o) begin
            if (lat < 0) lat = $urandom_range(0, 4);
            if (lat == 0) begin
                r.page     = '0;
                r.last     = 1'b0;
                r.done_cyc = cyc;
                p          = int'(mm_pg_addr_o);
                if (mm_alloc_o) begin
                    p = $urandom_range(16, OCC_MAX - 1);
                    for (int s = 0; s < 16; s++) begin
                        if (use_cnt[s] == 0) p = s;
                    end
                    use_cnt[p] = int'(mm_usecnt_o);
                    r.page     = AW'(p);
                end else if (mm_free_o) begin
                    r.last = (use_cnt[p] == 1);
                    if (use_cnt[p] > 0) use_cnt[p] = use_cnt[p] - 1;
                end else if (mm_force_free_o) begin
                    use_cnt[p] = 0;
                end else begin
                    use_cnt[p] = int'(mm_usecnt_o);
                end
                mm_pg_addr_alloc_i    = r.page;
                mm_free_last_usecnt_i = r.last;
                mm_done_i             = 1'b1;
                res_q.push_back(r);
                lat = -1;
            end else begin
                lat = lat - 1;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            // stray completion while nothing is outstanding
            mm_done_i             = 1'b1;
            mm_pg_addr_alloc_i    = AW'($urandom_range(0, OCC_MAX - 1));
            mm_free_last_usecnt_i = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- reference model: who is served next ----------------
    int   m_phase = 0;
    int   m_ptr   = 0;
    int   m_grant = 0;
    int   pk;
    bit   found;
    exp_t pe;

    always @(negedge clk) begin
        if (rst_i) begin
            m_phase = 0;
            m_ptr   = 0;
        end else begin
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int j = 0; j < N; j++) begin
                        pk = (m_ptr + j) % N;
                        if (!found && rq_req_i[pk] &&
                            !(rq_op_i[2*pk +: 2] == OP_ALLOC && mm_no_mem_i)) begin
                            found         = 1'b1;
                            m_grant       = pk;
                            pe.port       = pk;
                            pe.op         = rq_op_i[2*pk +: 2];
                            pe.page       = rq_pg_addr_i[AW*pk +: AW];
                            pe.usecnt     = rq_usecnt_i[UW*pk +: UW];
                            pe.strobe_cyc = cyc + 1;
                            exp_q.push_back(pe);
                        end
                    end
                    if (found) m_phase = 1;
                end
                1: if (mm_done_i) m_phase = 2;
                default: begin
                    m_ptr   = (m_grant + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    int   m_occ  = 0;
    int   m_peak = 0;
    int   nstb;
    exp_t me;
    res_t mr;

    always @(negedge clk) begin
        if (rst_i) begin
            m_occ  = 0;
            m_peak = 0;
        end else begin
            nstb = int'(mm_alloc_o) + int'(mm_free_o) + int'(mm_force_free_o) + int'(mm_set_usecnt_o);
            if (exp_q.size() > 0 && cyc == exp_q[0].strobe_cyc) check("strobe_start", nstb, 1);
            if (nstb > 0) begin
                if (exp_q.size() == 0 || cyc < exp_q[0].strobe_cyc) begin
                    check("strobe_unexpected", nstb, 0);
                end else begin
                    me = exp_q[0];
                    check("strobe_count", nstb, 1);
                    check("strobe_kind", 32'({mm_set_usecnt_o, mm_force_free_o, mm_free_o, mm_alloc_o}),
                          32'(1) << me.op);
                    if (me.op != OP_ALLOC) check("mm_pg_addr", 32'(mm_pg_addr_o), 32'(me.page));
                    if (me.op == OP_ALLOC || me.op == OP_SET)
                        check("mm_usecnt", 32'(mm_usecnt_o), 32'(me.usecnt));
                end
            end
            if (res_q.size() > 0 && cyc == res_q[0].done_cyc + 1) begin
                mr = res_q.pop_front();
                check("exp_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    check("done_port", 32'(rq_done_o), 32'(1) << me.port);
                    check("strobe_drop", nstb, 0);
                    if (me.op == OP_ALLOC) check("alloc_page", 32'(rq_pg_addr_o), 32'(mr.page));
                    if (me.op == OP_FREE)  check("free_last", 32'(rq_last_o), 32'(mr.last));
`ifdef SWC_ALLOC_ARB_STATS_EN
                    if (me.op == OP_ALLOC) m_occ = (m_occ < OCC_MAX) ? m_occ + 1 : OCC_MAX;
                    else if (me.op == OP_FORCE || (me.op == OP_FREE && mr.last))
                        m_occ = (m_occ > 0) ? m_occ - 1 : 0;
                    if (m_occ > m_peak) m_peak = m_occ;
`endif
                end
            end else if (rq_done_o != '0) begin
                check("done_unexpected", 32'(rq_done_o), 0);
            end
            for (int i = 0; i < N; i++) begin
                if (rq_done_o[i]) done_seen[i] = 1'b1;
            end
            check("occupied", 32'(occupied_o), m_occ);
            check("peak", 32'(peak_o), m_peak);
        end
    end

    // ---------------- main sequence ----------------
    task automatic clear_bench();
        rq_req_i  = '0;
        mm_done_i = 1'b0;
        mm_free_last_usecnt_i = 1'b0;
        lat = -1;
        for (int i = 0; i < N; i++) done_seen[i] = 1'b0;
        for (int p = 0; p < OCC_MAX; p++) use_cnt[p] = 0;
        exp_q.delete();
        res_q.delete();
    endtask

    task automatic mid_reset();
        int w;
        w = 0;
        while (!(mm_alloc_o || mm_free_o || mm_force_free_o || mm_set_usecnt_o) && w < 60) begin
            respond();
            drive_requests(1'b1);
            @(posedge clk); #1;
            w++;
        end
        check("reset_wait_busy", 32'(mm_alloc_o || mm_free_o || mm_force_free_o || mm_set_usecnt_o), 1);
        rst_i = 1'b1;
        clear_bench();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
    endtask

    initial begin
        rst_i              = 1'b1;
        rq_req_i           = '0;
        rq_op_i            = '0;
        rq_pg_addr_i       = '0;
        rq_usecnt_i        = '0;
        mm_done_i          = 1'b0;
        mm_pg_addr_alloc_i = '0;
        mm_no_mem_i        = 1'b0;
        mm_free_last_usecnt_i = 1'b0;
        clear_bench();
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            if (c == 1200) begin
                mid_reset();
            end else begin
                respond();
                drive_requests(1'b1);
            end
        end

        mm_no_mem_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            respond();
            drive_requests(1'b0);
        end
        @(negedge clk);
        check("drain_exp_q", 32'(exp_q.size()), 0);
        check("drain_res_q", 32'(res_q.size()), 0);
        check("drain_requests", 32'(rq_req_i), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
